// File: rtl/mplier_issue_ctrl.sv
// Operand-issue and result-capture controller for the sequential signed
// multiplier core. Operand pairs queue in a small FIFO, one multiply is in
// flight at a time, and each product (or a watchdog abort) lands in a
// one-entry output register presented on a valid/ready stream.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a queued pair and a free output register
// LOAD   | core_load pulse; watchdog armed
// WAIT   | waiting for core_done (first WAIT cycle ignores a stale done)
// HOLD   | capture while the output register was still occupied; unreachable
module mplier_issue_ctrl #(
    parameter int N       = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_mcand,
    input  logic [N-1:0]   in_mplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic           out_err,
    output logic           core_load,
    output logic [N-1:0]   core_mcand,
    output logic [N-1:0]   core_mplier,
    input  logic [2*N-1:0] core_product,
    input  logic           core_done,
    output logic           busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WD_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [N-1:0]    fifo_mcand  [DEPTH];
    logic [N-1:0]    fifo_mplier [DEPTH];
    logic [TW-1:0]   wd_cnt;
    logic            core_load_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            first_wait;
    logic            out_held;

    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    // Only issue when the output register is free or being drained this
    // cycle, so at most one result is ever outstanding.
    assign pop        = (state == S_IDLE) && !fifo_empty && (!out_valid || out_ready);
    // The watchdog is loaded with its full count on entry to WAIT, so a full
    // count marks the first WAIT cycle, where done may still be stale.
    assign first_wait = (wd_cnt == WD_LAST);
    assign out_held   = out_valid && !out_ready;
    assign busy       = (state != S_IDLE) || !fifo_empty;
    // Load must never reach the core while the block is held in reset.
    assign core_load  = core_load_q && !rst;

    // FIFO storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mcand[wr_ptr[AW-1:0]]  <= in_mcand;
            fifo_mplier[wr_ptr[AW-1:0]] <= in_mplier;
        end
    end

    // Issue FSM, watchdog, FIFO pointers and the output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wd_cnt      <= '0;
            core_load_q <= 1'b0;
            core_mcand  <= '0;
            core_mplier <= '0;
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            out_product <= '0;
        end else begin
            core_load_q <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        core_mcand  <= fifo_mcand[rd_ptr[AW-1:0]];
                        core_mplier <= fifo_mplier[rd_ptr[AW-1:0]];
                        rd_ptr      <= rd_ptr + PTR_ONE;
                        core_load_q <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wd_cnt <= WD_LAST;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done && !first_wait) begin
                        out_product <= core_product;
                        out_err     <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= out_held ? S_HOLD : S_IDLE;
                    end else if (wd_cnt == '0) begin
                        out_product <= '0;
                        out_err     <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= out_held ? S_HOLD : S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - WD_ONE;
                    end
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // HOLD can only be reached if the IDLE gating were broken.
    hold_unreachable: assert property (@(posedge clk) disable iff (rst) state != S_HOLD);

endmodule

// File: tb/tb_mplier_issue_ctrl.sv
// Bench for mplier_issue_ctrl: a latency-programmable multiplier core model,
// a queue-based reference of the expected results, directed scenarios and a
// randomized run.
module tb_mplier_issue_ctrl;

    localparam int N       = 32;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_mcand;
    logic [31:0]   in_mplier;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_product;
    logic          out_err;
    logic          core_load;
    logic [31:0]   core_mcand;
    logic [31:0]   core_mplier;
    logic [63:0]   core_product = 64'd0;
    logic          core_done = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cfg_lat = 12;   // core latency for the next op: 0 = never done, -1 = random
    int next_lat = 12;

    mplier_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_err(out_err),
        .core_load(core_load), .core_mcand(core_mcand), .core_mplier(core_mplier),
        .core_product(core_product), .core_done(core_done),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Core model: done stays stale through the load cycle and the next one,
    // then rises lat cycles after the load cycle with the new product.
    logic signed [31:0] core_a = 32'sd0;
    logic signed [31:0] core_b = 32'sd0;
    int  core_cnt = 0;
    int  core_lat = 0;
    logic core_run = 1'b0;
    always @(posedge clk) begin
        if (core_load) begin
            core_a   <= core_mcand;
            core_b   <= core_mplier;
            core_cnt <= 1;
            core_lat <= next_lat;
            core_run <= 1'b1;
        end else if (core_run) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 1) core_done <= 1'b0;
            if (core_lat != 0 && core_cnt == core_lat - 1) begin
                core_done    <= 1'b1;
                core_product <= core_a * core_b;
                core_run     <= 1'b0;
            end
            if (core_cnt > 200) core_run <= 1'b0;
        end
    end

    // Reference: accepted pairs queue up, each load takes the oldest, and the
    // result for that op is its product, or an error if the core latency
    // exceeds the watchdog window.
    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct { logic [63:0] p; logic e; } res_t;
    pair_t pq[$];
    res_t  rq[$];
    pair_t hd;
    res_t  rs;
    int    lat;
    int    n_push = 0, n_load = 0, n_res = 0, valid_seen = 0;
    int    last_load_cyc = 0, last_rise_cyc = 0;
    logic  prev_ov = 1'b0, prev_hs = 1'b0, prev_load = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("load_in_rst", {63'd0, core_load}, 64'd0);
            pq.delete();
            rq.delete();
            n_push = 0; n_load = 0; n_res = 0;
            prev_ov = 1'b0; prev_hs = 1'b0; prev_load = 1'b0;
        end else begin
            if (core_load) begin
                chk("load_back_to_back", {63'd0, prev_load}, 64'd0);
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL load_without_pair: got load expected none (cycle %0d)", cyc);
                end else begin
                    hd = pq.pop_front();
                    chk("core_mcand", {32'd0, core_mcand}, {32'd0, hd.a});
                    chk("core_mplier", {32'd0, core_mplier}, {32'd0, hd.b});
                    lat = (cfg_lat < 0) ? int'($urandom_range(3, 40)) : cfg_lat;
                    next_lat = lat;
                    rs.e = (lat == 0) || (lat > TIMEOUT);
                    rs.p = rs.e ? 64'd0 : 64'(longint'($signed(hd.a)) * longint'($signed(hd.b)));
                    rq.push_back(rs);
                end
                n_load++;
                last_load_cyc = cyc;
            end
            prev_load = core_load;
            if (out_valid) begin
                valid_seen++;
                if (!prev_ov || prev_hs) begin
                    n_res++;
                    last_rise_cyc = cyc;
                end
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got product %h expected no result (cycle %0d)", out_product, cyc);
                end else begin
                    chk("out_product", out_product, rq[0].p);
                    chk("out_err", {63'd0, out_err}, {63'd0, rq[0].e});
                    if (out_ready) void'(rq.pop_front());
                end
            end
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
            chk("in_ready", {63'd0, in_ready}, {63'd0, ((n_push - n_load) < DEPTH)});
            chk("busy", {63'd0, busy}, {63'd0, ((n_push - n_load) > 0) || ((n_load - n_res) > 0)});
            if (in_valid && in_ready) begin
                pq.push_back('{in_mcand, in_mplier});
                n_push++;
            end
        end
    end

    // Drive one pair until accepted; t is the accepting cycle.
    task automatic push(input logic [31:0] a, input logic [31:0] b, output int t);
        int n = 0;
        in_valid = 1'b1; in_mcand = a; in_mplier = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 100 cycles expected acceptance");
        end
        t = cyc;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    // Wait for a handshake on the output stream; c is its cycle.
    task automatic get_result(output logic [63:0] p, output logic e, output int c);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL result_timeout: got no result in 200 cycles expected one");
        end
        p = out_product; e = out_err; c = cyc;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: rand_op = 32'h8000_0000;
            1: rand_op = 32'h7FFF_FFFF;
            2: rand_op = 32'h0000_0000;
            3: rand_op = 32'hFFFF_FFFF;
            default: rand_op = $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] p, p2;
        logic e, e2;
        int t, t2, c, c2, r, n, loads0, vs0;
        logic stable;

        rst = 1'b1; in_valid = 1'b0; in_mcand = '0; in_mplier = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_core_load", {63'd0, core_load}, 64'd0);
        chk("rst_core_ops", {core_mcand, core_mplier}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // single pair, latency
        push(32'd7, 32'hFFFF_FFFD, t);
        get_result(p, e, c);
        chk("t1_load_lat", 64'(last_load_cyc - t), 64'd2);
        chk("t1_valid_lat", 64'(c - t), 64'd15);
        chk("t1_product", p, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("t1_err", {63'd0, e}, 64'd0);

        // signed extremes back to back
        push(32'h8000_0000, 32'h8000_0000, t);
        push(32'h7FFF_FFFF, 32'hFFFF_FFFF, t2);
        get_result(p, e, c);
        get_result(p2, e2, c2);
        chk("t2_min_min", p, 64'h4000_0000_0000_0000);
        chk("t2_max_neg1", p2, 64'hFFFF_FFFF_8000_0001);
        chk("t2_first_lat", 64'(c - t), 64'd15);
        chk("t2_spacing", 64'(c2 - c), 64'd14);

        // three pairs into a two-deep FIFO
        push(32'd3, 32'd5, t);
        push(32'hFFFF_FFFC, 32'd6, t);
        push(32'd100, 32'hFFFF_FF9C, t);
        @(negedge clk);
        chk("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t3_full_busy", {63'd0, busy}, 64'd1);
        get_result(p, e, c);
        chk("t3_r0", p, 64'd15);
        get_result(p, e, c);
        chk("t3_r1", p, 64'hFFFF_FFFF_FFFF_FFE8);
        get_result(p, e, c);
        chk("t3_r2", p, 64'hFFFF_FFFF_FFFF_D8F0);

        // output backpressure blocks the next issue
        out_ready = 1'b0;
        push(32'd11, 32'd13, t);
        push(32'hFFFF_FFFB, 32'hFFFF_FFFB, t2);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("t4_first_seen", {63'd0, out_valid}, 64'd1);
        loads0 = n_load;
        stable = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_product !== 64'd143 || !out_valid) stable = 1'b0;
        end
        chk("t4_no_load", 64'(n_load - loads0), 64'd0);
        chk("t4_held", {63'd0, stable}, 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        r = cyc;
        get_result(p, e, c);
        chk("t4_r0", p, 64'd143);
        chk("t4_r0_cycle", 64'(c - r), 64'd0);
        get_result(p, e, c);
        chk("t4_r1", p, 64'd25);
        chk("t4_reload", 64'(last_load_cyc - r), 64'd1);

        // watchdog: never done, done on the last window cycle, one cycle late
        cfg_lat = 0;
        push(32'd1234, 32'd5, t);
        get_result(p, e, c);
        chk("t5_err", {63'd0, e}, 64'd1);
        chk("t5_product", p, 64'd0);
        chk("t5_abort_lat", 64'(c - last_load_cyc), 64'd33);
        cfg_lat = 32;
        push(32'hFFFF_FFF9, 32'd8, t);
        get_result(p, e, c);
        chk("t5_edge_err", {63'd0, e}, 64'd0);
        chk("t5_edge_product", p, 64'hFFFF_FFFF_FFFF_FFC8);
        cfg_lat = 33;
        push(32'd2, 32'd3, t);
        get_result(p, e, c);
        chk("t5_late_err", {63'd0, e}, 64'd1);
        chk("t5_late_product", p, 64'd0);
        cfg_lat = 12;
        push(32'd9, 32'hFFFF_FFF7, t);
        get_result(p, e, c);
        chk("t5_recover_err", {63'd0, e}, 64'd0);
        chk("t5_recover_product", p, 64'hFFFF_FFFF_FFFF_FFAF);

        // reset in WAIT with one pair queued
        push(32'd21, 32'd2, t);
        push(32'd4, 32'd4, t2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        vs0 = valid_seen;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        repeat (60) @(posedge clk);
        chk("t6_no_result", 64'(valid_seen - vs0), 64'd0);
        #1;

        // randomized traffic, random core latency and backpressure
        cfg_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_mcand  = rand_op();
            in_mplier = rand_op();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (300) @(posedge clk);
        chk("drain_results", 64'(rq.size()), 64'd0);
        chk("drain_pairs", 64'(pq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
